// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage in front of a combinational program
//               ROM. Owns the PC, captures ROM words into an instruction
//               register handed to decode over valid/ready, applies
//               jump/call/return/soft-reset redirects from execute and keeps
//               a hardware return-address stack with a sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int ADDR_BITS   = 8,
    parameter int WORD_WIDTH  = 24,
    parameter int STACK_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [ADDR_BITS-1:0]   rom_addr,
    input  logic [WORD_WIDTH-1:0]  rom_data,
    output logic                   ir_valid,
    input  logic                   ir_ready,
    output logic [WORD_WIDTH-17:0] ir_opcode,
    output logic [15:0]            ir_operand,
    output logic [ADDR_BITS-1:0]   ir_pc,
    input  logic [2:0]             flow_cmd,
    input  logic [ADDR_BITS-1:0]   flow_target,
    input  logic [ADDR_BITS-1:0]   flow_pc,
    output logic                   stack_err
);

    // sp counts valid entries, so it must reach STACK_DEPTH itself
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int OP_W  = WORD_WIDTH - 16;

    localparam logic [2:0] c_cmd_jump  = 3'd1;
    localparam logic [2:0] c_cmd_call  = 3'd2;
    localparam logic [2:0] c_cmd_ret   = 3'd3;
    localparam logic [2:0] c_cmd_sreset = 3'd4;

    localparam logic [SP_W-1:0]      c_depth    = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0]      c_sp_one   = SP_W'(1);
    localparam logic [ADDR_BITS-1:0] c_addr_one = ADDR_BITS'(1);

    logic [ADDR_BITS-1:0] r_pc;
    logic                 r_ir_valid;
    logic [OP_W-1:0]      r_ir_opcode;
    logic [15:0]          r_ir_operand;
    logic [ADDR_BITS-1:0] r_ir_pc;
    logic [SP_W-1:0]      r_sp;
    logic                 r_stack_err;
    logic [ADDR_BITS-1:0] r_stack [STACK_DEPTH];

    logic [ADDR_BITS-1:0] w_pc_nxt;
    logic                 w_ir_valid_nxt;
    logic                 w_ir_load;
    logic [SP_W-1:0]      w_sp_nxt;
    logic                 w_stack_err_nxt;
    logic                 w_push;
    logic                 w_fire;
    logic [IDX_W-1:0]     w_push_idx;
    logic [IDX_W-1:0]     w_pop_idx;
    logic [ADDR_BITS-1:0] w_ret_addr;

    assign w_fire     = !r_ir_valid || ir_ready;
    assign w_push_idx = IDX_W'(r_sp);
    assign w_pop_idx  = IDX_W'(r_sp - c_sp_one);
    // Wraps naturally at the top of the address space (255 -> 0)
    assign w_ret_addr = flow_pc + c_addr_one;

    // Next-state selection: any redirect beats fetch and flushes the IR
    always_comb begin
        w_pc_nxt        = r_pc;
        w_ir_valid_nxt  = r_ir_valid;
        w_ir_load       = 1'b0;
        w_sp_nxt        = r_sp;
        w_stack_err_nxt = r_stack_err;
        w_push          = 1'b0;
        case (flow_cmd)
            c_cmd_jump: begin
                w_ir_valid_nxt = 1'b0;
                w_pc_nxt       = flow_target;
            end
            c_cmd_call: begin
                w_ir_valid_nxt = 1'b0;
                w_pc_nxt       = flow_target;
                if (r_sp < c_depth) begin
                    w_push   = 1'b1;
                    w_sp_nxt = r_sp + c_sp_one;
                end else begin
                    // Full stack: the return address is lost, jump still taken
                    w_stack_err_nxt = 1'b1;
                end
            end
            c_cmd_ret: begin
                w_ir_valid_nxt = 1'b0;
                if (r_sp != '0) begin
                    w_pc_nxt = r_stack[w_pop_idx];
                    w_sp_nxt = r_sp - c_sp_one;
                end else begin
                    w_pc_nxt        = '0;
                    w_stack_err_nxt = 1'b1;
                end
            end
            c_cmd_sreset: begin
                w_ir_valid_nxt  = 1'b0;
                w_pc_nxt        = '0;
                w_sp_nxt        = '0;
                w_stack_err_nxt = 1'b0;
            end
            default: begin
                // No redirect (0 and the unused codes 5..7): normal fetch
                if (w_fire) begin
                    w_ir_load      = 1'b1;
                    w_ir_valid_nxt = 1'b1;
                    w_pc_nxt       = r_pc + c_addr_one;
                end
            end
        endcase
    end

    // PC, IR, stack pointer and error flag with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= '0;
            r_ir_valid   <= 1'b0;
            r_ir_opcode  <= '0;
            r_ir_operand <= '0;
            r_ir_pc      <= '0;
            r_sp         <= '0;
            r_stack_err  <= 1'b0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_ir_valid  <= w_ir_valid_nxt;
            r_sp        <= w_sp_nxt;
            r_stack_err <= w_stack_err_nxt;
            if (w_ir_load) begin
                r_ir_opcode  <= rom_data[WORD_WIDTH-1:16];
                r_ir_operand <= rom_data[15:0];
                r_ir_pc      <= r_pc;
            end
        end
    end

    // Return-stack storage; contents are meaningless until pushed, so no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_ret_addr;
        end
    end

    assign rom_addr   = r_pc;
    assign ir_valid   = r_ir_valid;
    assign ir_opcode  = r_ir_opcode;
    assign ir_operand = r_ir_operand;
    assign ir_pc      = r_ir_pc;
    assign stack_err  = r_stack_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed plus randomized bench for fetch_unit against a
//               queue-based reference model of the fetch/redirect rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    localparam int AB = 8;
    localparam int WW = 24;
    localparam int SD = 8;
    localparam logic [7:0] c_op_ior = 8'h0B;
    localparam logic [7:0] c_op_ldi = 8'h01;

    logic          clk;
    logic          rst_n;
    logic [AB-1:0] rom_addr;
    logic [WW-1:0] rom_data;
    logic          ir_valid;
    logic          ir_ready;
    logic [7:0]    ir_opcode;
    logic [15:0]   ir_operand;
    logic [AB-1:0] ir_pc;
    logic [2:0]    flow_cmd;
    logic [AB-1:0] flow_target;
    logic [AB-1:0] flow_pc;
    logic          stack_err;

    logic [WW-1:0] mem [256];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_pc;
    bit m_valid;
    int m_irpc;
    int m_word;
    bit m_err;
    int m_stk[$];

    fetch_unit #(.ADDR_BITS(AB), .WORD_WIDTH(WW), .STACK_DEPTH(SD)) dut (
        .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_opcode(ir_opcode),
        .ir_operand(ir_operand), .ir_pc(ir_pc), .flow_cmd(flow_cmd),
        .flow_target(flow_target), .flow_pc(flow_pc), .stack_err(stack_err)
    );

    assign rom_data = mem[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_valid = 0; m_irpc = 0; m_word = 0; m_err = 0;
        m_stk.delete();
    endtask

    // One clock of architectural behaviour, evaluated from pre-edge state
    task automatic model_edge(input int cmd, input int tgt, input int fpc, input bit rdy);
        case (cmd)
            1: begin m_pc = tgt; m_valid = 0; end
            2: begin
                if (m_stk.size() < SD) m_stk.push_back((fpc + 1) % 256);
                else m_err = 1;
                m_pc = tgt; m_valid = 0;
            end
            3: begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_pc = 0; m_err = 1; end
                m_valid = 0;
            end
            4: begin m_pc = 0; m_stk.delete(); m_valid = 0; m_err = 0; end
            default: begin
                if (!m_valid || rdy) begin
                    m_word = int'(mem[m_pc]); m_irpc = m_pc; m_valid = 1;
                    m_pc = (m_pc + 1) % 256;
                end
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rom_addr"}, 32'(rom_addr), 32'(m_pc));
        chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(m_valid));
        chk({tag, ".stack_err"}, 32'(stack_err), 32'(m_err));
        if (m_valid) begin
            chk({tag, ".ir_pc"}, 32'(ir_pc), 32'(m_irpc));
            chk({tag, ".ir_opcode"}, 32'(ir_opcode), 32'((m_word >> 16) & 8'hFF));
            chk({tag, ".ir_operand"}, 32'(ir_operand), 32'(m_word & 16'hFFFF));
        end
    endtask

    task automatic step(input string tag, input int cmd, input int tgt, input int fpc, input bit rdy);
        flow_cmd    = 3'(cmd);
        flow_target = AB'(tgt);
        flow_pc     = AB'(fpc);
        ir_ready    = rdy;
        @(posedge clk);
        model_edge(cmd, tgt, fpc, rdy);
        #1;
        check_all(tag);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = WW'($urandom);
        mem[1]  = {c_op_ior, 16'h0002};
        mem[20] = {c_op_ldi, 16'h0005};

        rst_n = 1'b0; flow_cmd = 3'd0; flow_target = '0; flow_pc = '0; ir_ready = 1'b1;
        model_reset();
        #12;
        check_all("reset");
        chk("reset.ir_pc0", 32'(ir_pc), 32'h0);
        chk("reset.ir_opcode0", 32'(ir_opcode), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming from address 0 until ir_pc = 3
        for (int i = 0; i < 4; i++) begin
            step("stream", 0, 0, 0, 1);
            if (i == 1) begin
                chk("ior.opcode", 32'(ir_opcode), 32'(c_op_ior));
                chk("ior.operand", 32'(ir_operand), 32'h2);
            end
        end

        // Stall three cycles at ir_pc = 3
        for (int i = 0; i < 3; i++) begin
            step("stall", 0, 0, 0, 0);
            chk("stall.rom_addr", 32'(rom_addr), 32'd4);
            chk("stall.ir_pc", 32'(ir_pc), 32'd3);
        end
        step("release", 0, 0, 0, 1);
        chk("release.ir_pc", 32'(ir_pc), 32'd4);
        for (int i = 0; i < 6; i++) step("stream2", 0, 0, 0, 1);

        // Call to 20 from 8, then return to 9
        step("call", 2, 20, 8, 1);
        chk("call.bubble", 32'(ir_valid), 32'd0);
        step("call.tgt", 0, 0, 0, 1);
        chk("call.ir_pc", 32'(ir_pc), 32'd20);
        chk("call.ldi", 32'(ir_opcode), 32'(c_op_ldi));
        step("call.run", 0, 0, 0, 1);
        step("ret", 3, 0, 0, 1);
        chk("ret.bubble", 32'(ir_valid), 32'd0);
        step("ret.tgt", 0, 0, 0, 1);
        chk("ret.ir_pc", 32'(ir_pc), 32'd9);

        // Nest STACK_DEPTH+1 calls: last push overflows but still jumps
        for (int i = 0; i <= SD; i++) step("nest", 2, 30 + i, 40 + i, 1);
        chk("nest.err", 32'(stack_err), 32'd1);
        chk("nest.target", 32'(rom_addr), 32'd38);
        step("nest.pop", 3, 0, 0, 1);
        chk("nest.pop_addr", 32'(rom_addr), 32'd48);
        for (int i = 1; i < SD; i++) step("unwind", 3, 0, 0, 1);
        step("underflow", 3, 0, 0, 1);
        chk("underflow.pc", 32'(rom_addr), 32'd0);
        chk("underflow.err", 32'(stack_err), 32'd1);

        // PC wrap and call from 255 returning to 0
        step("to254", 1, 254, 0, 1);
        step("wrap", 0, 0, 0, 1);
        step("wrap", 0, 0, 0, 1);
        chk("wrap.rom_addr", 32'(rom_addr), 32'd0);
        chk("wrap.ir_pc", 32'(ir_pc), 32'd255);
        step("wrap", 0, 0, 0, 1);
        step("call255", 2, 100, 255, 1);
        step("ret255", 3, 0, 0, 1);
        chk("ret255.pc", 32'(rom_addr), 32'd0);

        // Jump with ir_ready high discards fall-through
        step("pre", 0, 0, 0, 1);
        step("pre", 0, 0, 0, 1);
        step("jmp", 1, 9, 0, 1);
        chk("jmp.flush", 32'(ir_valid), 32'd0);
        step("jmp.tgt", 0, 0, 0, 1);
        chk("jmp.ir_pc", 32'(ir_pc), 32'd9);

        // Soft reset clears the sticky error
        step("sreset", 4, 0, 0, 1);
        chk("sreset.err", 32'(stack_err), 32'd0);
        chk("sreset.pc", 32'(rom_addr), 32'd0);
        step("sreset.run", 0, 0, 0, 1);
        chk("sreset.ir_pc", 32'(ir_pc), 32'd0);

        // Randomized traffic against the model, with one async reset mid-run
        for (int i = 0; i < 400; i++) begin
            int r;
            int cmd;
            r = int'($urandom_range(0, 99));
            if (r < 70) cmd = 0;
            else if (r < 78) cmd = 1;
            else if (r < 87) cmd = 2;
            else if (r < 95) cmd = 3;
            else if (r < 97) cmd = 4;
            else cmd = 5 + int'($urandom_range(0, 2));
            step("rand", cmd, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) != 0));
            if (i == 200) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                check_all("async_rst");
                flow_cmd = 3'd2;
                @(posedge clk);
                #1;
                check_all("async_hold");
                @(negedge clk);
                rst_n = 1'b1;
                step("after_rst", 0, 0, 0, 1);
                chk("after_rst.ir_pc", 32'(ir_pc), 32'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
